// File: rtl/serial_subtractor_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM state encoding and
// a constant-evaluable ceiling-log2 helper used to size the bit counter.
package serial_subtractor_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Ceiling log2; clog2(1)=0, clog2(8)=3, clog2(9)=4.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/serial_subtractor_full_subtractor_cell.sv
// One-bit full subtractor: diff = a - b - bin, with borrow out.
// Dual of the adder's full-adder cell (borrow replaces carry).
module full_subtractor_cell (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic diff,
  output logic bout
);

  logic a_xor_b;

  assign a_xor_b = a ^ b;
  assign diff    = a_xor_b ^ bin;
  // Borrow when b exceeds a outright, or when a==b and a borrow ripples in.
  assign bout    = (~a & b) | (~a_xor_b & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial two's-complement subtractor: d = a - b - bin, LSB first, one bit
// per clock. A single full-subtractor cell with a registered borrow stands in
// for a ripple chain. Results are published only at completion.
module serial_subtractor
  import serial_subtractor_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] d,
  output logic             bout,
  output logic             ovf,
  output logic             zero
);

  localparam int CW = clog2(WIDTH) + 1;

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] a_sh_reg, b_sh_reg, res_reg, d_reg;
  logic             br_reg, bout_reg, ovf_reg, zero_reg;
  logic [CW-1:0]    count_reg;

  logic             cell_diff, cell_bout;
  logic             accept, last_bit;
  logic [WIDTH-1:0] res_shifted;

  full_subtractor_cell u_cell (
    .a    (a_sh_reg[0]),
    .b    (b_sh_reg[0]),
    .bin  (br_reg),
    .diff (cell_diff),
    .bout (cell_bout)
  );

  // A start is honoured only when no operation is in flight.
  assign accept   = start && (state_reg != RUN);
  assign last_bit = (state_reg == RUN) && (count_reg == CW'(WIDTH - 1));

  // Result register shifts right; the new difference bit enters at the MSB,
  // so after WIDTH steps the LSB-first stream lands in natural order.
  genvar gi;
  generate
    for (gi = 0; gi < WIDTH - 1; gi++) begin : g_res_shift
      assign res_shifted[gi] = res_reg[gi+1];
    end
  endgenerate
  assign res_shifted[WIDTH-1] = cell_diff;

  // Next-state logic.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (start) state_next = RUN;
      RUN:     if (last_bit) state_next = DONE;
      DONE:    state_next = start ? RUN : IDLE;
      default: state_next = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  // Operand capture, per-bit shifting and borrow/count tracking.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_sh_reg  <= '0;
      b_sh_reg  <= '0;
      res_reg   <= '0;
      br_reg    <= 1'b0;
      count_reg <= '0;
    end else if (accept) begin
      a_sh_reg  <= a;
      b_sh_reg  <= b;
      res_reg   <= '0;
      br_reg    <= bin;
      count_reg <= '0;
    end else if (state_reg == RUN) begin
      a_sh_reg  <= a_sh_reg >> 1;
      b_sh_reg  <= b_sh_reg >> 1;
      res_reg   <= res_shifted;
      br_reg    <= cell_bout;
      count_reg <= count_reg + CW'(1);
    end
  end

  // Published results change only on the edge that processes the MSB.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      d_reg    <= '0;
      bout_reg <= 1'b0;
      ovf_reg  <= 1'b0;
      zero_reg <= 1'b0;
    end else if (last_bit) begin
      d_reg    <= res_shifted;
      bout_reg <= cell_bout;
      // Signed overflow: borrow into MSB differs from borrow out of MSB.
      ovf_reg  <= br_reg ^ cell_bout;
      zero_reg <= (res_shifted == '0);
    end
  end

  assign busy = (state_reg == RUN);
  assign done = (state_reg == DONE);
  assign d    = d_reg;
  assign bout = bout_reg;
  assign ovf  = ovf_reg;
  assign zero = zero_reg;

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor (WIDTH=8): vector table, hand
// sequences for busy-start, back-to-back and mid-run reset, and a random sweep.
module tb_serial_subtractor;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] a, b;
  logic         bin;
  logic         busy, done, bout, ovf, zero;
  logic [W-1:0] d;

  serial_subtractor #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .bin(bin),
    .busy(busy), .done(done), .d(d), .bout(bout), .ovf(ovf), .zero(zero)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         bin;
    logic [W-1:0] d;
    logic         bout;
    logic         ovf;
    logic         zero;
  } vec_t;

  vec_t   sb_q[$];
  int     asserts = 0;
  int     fails   = 0;
  int     done_count = 0;
  logic   prev_done = 1'b0;
  logic [W-1:0] last_d = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    asserts++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: unsigned 9-bit difference gives borrow; signed overflow
  // occurs when operand signs differ and the result sign differs from a.
  function automatic vec_t model(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic tbin);
    vec_t v;
    logic [W:0] full;
    full   = {1'b0, ta} - {1'b0, tb} - {{W{1'b0}}, tbin};
    v.a    = ta;
    v.b    = tb;
    v.bin  = tbin;
    v.d    = full[W-1:0];
    v.bout = full[W];
    v.ovf  = (ta[W-1] != tb[W-1]) && (full[W-1] != ta[W-1]);
    v.zero = (full[W-1:0] == '0);
    return v;
  endfunction

  // Scoreboard consumer: every done pulse pops one expectation.
  always @(negedge clk) begin
    if (done) begin
      vec_t e;
      done_count++;
      chk("done_single_cycle", {31'b0, prev_done}, 32'd0);
      if (sb_q.size() == 0) begin
        chk("unexpected_done", 32'd1, 32'd0);
      end else begin
        e = sb_q.pop_front();
        $display("op a=%02h b=%02h bin=%0d -> d=%02h bout=%0d ovf=%0d zero=%0d (exp %02h %0d %0d %0d)",
                 e.a, e.b, e.bin, d, bout, ovf, zero, e.d, e.bout, e.ovf, e.zero);
        chk("d",    {24'b0, d},    {24'b0, e.d});
        chk("bout", {31'b0, bout}, {31'b0, e.bout});
        chk("ovf",  {31'b0, ovf},  {31'b0, e.ovf});
        chk("zero", {31'b0, zero}, {31'b0, e.zero});
      end
    end
    prev_done <= done;
  end

  // Issue one operation. chain=1: caller is at the negedge of a DONE cycle and
  // the start is driven there. intrude_at>0: assert a conflicting start while busy.
  task automatic run_op(input vec_t v, input bit chain, input int intrude_at);
    int edges;
    if (!chain) @(negedge clk);
    a = v.a; b = v.b; bin = v.bin; start = 1'b1;
    sb_q.push_back(v);
    @(posedge clk);
    #1;
    start = 1'b0;
    chk("busy_after_accept", {31'b0, busy}, 32'd1);
    chk("done_low_after_accept", {31'b0, done}, 32'd0);
    edges = 1;
    while (edges < 30) begin
      @(negedge clk);
      if (done) break;
      chk("d_held_while_busy", {24'b0, d}, {24'b0, last_d});
      // Scramble inputs; they must not disturb the operation in flight.
      a = W'($urandom); b = W'($urandom); bin = 1'($urandom);
      if (edges == intrude_at) begin
        a = 8'hFF; b = 8'hFF; start = 1'b1;
      end else begin
        start = 1'b0;
      end
      @(posedge clk);
      edges++;
    end
    start = 1'b0;
    chk("latency_edges", edges, 32'd9);
    last_d = v.d;
  endtask

  vec_t table_v[6];
  vec_t v;
  int   dc0;

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    table_v[0] = '{8'h05, 8'h03, 1'b0, 8'h02, 1'b0, 1'b0, 1'b0};
    table_v[1] = '{8'h03, 8'h05, 1'b0, 8'hFE, 1'b1, 1'b0, 1'b0};
    table_v[2] = '{8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1, 1'b0};
    table_v[3] = '{8'h7F, 8'hFF, 1'b0, 8'h80, 1'b1, 1'b1, 1'b0};
    table_v[4] = '{8'h00, 8'h00, 1'b1, 8'hFF, 1'b1, 1'b0, 1'b0};
    table_v[5] = '{8'h10, 8'h10, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1};

    rst = 1'b1; start = 1'b0; a = '0; b = '0; bin = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_done", {31'b0, done}, 32'd0);
    chk("rst_d",    {24'b0, d},    32'd0);
    chk("rst_bout", {31'b0, bout}, 32'd0);
    chk("rst_ovf",  {31'b0, ovf},  32'd0);
    chk("rst_zero", {31'b0, zero}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 6; i++) run_op(table_v[i], 1'b0, 0);

    // Start while busy is ignored: exactly one done, first operands win.
    repeat (2) @(negedge clk);
    dc0 = done_count;
    v = '{8'h20, 8'h01, 1'b0, 8'h1F, 1'b0, 1'b0, 1'b0};
    run_op(v, 1'b0, 3);
    repeat (4) @(negedge clk);
    chk("single_done_pulse", done_count - dc0, 32'd1);

    // Back-to-back: second start issued in the DONE cycle.
    run_op(model(8'h40, 8'h15, 1'b1), 1'b0, 0);
    run_op(model(8'h01, 8'h02, 1'b1), 1'b1, 0);
    repeat (2) @(negedge clk);

    // Reset mid-run: outputs clear asynchronously, pending result discarded.
    v = model(8'h55, 8'h22, 1'b0);
    a = v.a; b = v.b; bin = v.bin; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (4) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    chk("midrst_busy", {31'b0, busy}, 32'd0);
    chk("midrst_done", {31'b0, done}, 32'd0);
    chk("midrst_d",    {24'b0, d},    32'd0);
    chk("midrst_bout", {31'b0, bout}, 32'd0);
    chk("midrst_ovf",  {31'b0, ovf},  32'd0);
    chk("midrst_zero", {31'b0, zero}, 32'd0);
    last_d = '0;
    @(negedge clk);
    rst = 1'b0;
    run_op('{8'h0A, 8'h0A, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1}, 1'b0, 0);

    // Random sweep against the reference model.
    for (int i = 0; i < 24; i++) begin
      run_op(model(W'($urandom), W'($urandom), 1'($urandom)), 1'b0, 0);
    end

    repeat (3) @(negedge clk);
    chk("scoreboard_empty", sb_q.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
    $finish;
  end

endmodule
